// File: rtl/data_memory.sv
// Byte-addressed data memory for the MEM stage: big-endian 16-bit word and
// 8-bit byte loads/stores, registered load data and range-error flag, plus a
// combinational byte-peek port for debug.
module data_memory #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              byte_enable,
  output logic [DATA_W-1:0] Data_out,
  output logic              addr_err,
  input  logic [8:0]        dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int DEPTH_M1 = DEPTH - 1;

  // Limits are compared against a zero-extended address so that every
  // address bit participates and word accesses at the top cannot wrap.
  localparam logic [ADDR_W:0] BYTE_LIM = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] WORD_LIM = DEPTH_M1[ADDR_W:0];

  logic [7:0]        mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              addr_err_q, addr_err_d;

  logic              in_range;
  logic              access;
  logic              do_store;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx1;

  assign idx      = address[IDX_W-1:0];
  assign idx1     = idx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign in_range = byte_enable ? ({1'b0, address} < BYTE_LIM)
                                : ({1'b0, address} < WORD_LIM);
  assign access   = dm_enable && (MemWrite || MemRead);
  assign do_store = dm_enable && MemWrite && in_range;

  // Next-state for load result and error flag; a store wins over a load.
  always_comb begin
    data_out_d = data_out_q;
    addr_err_d = addr_err_q;
    if (access) begin
      addr_err_d = !in_range;
      if (MemRead && !MemWrite) begin
        if (!in_range)
          data_out_d = '0;
        else if (byte_enable)
          data_out_d = {8'h00, mem_q[idx]};
        else
          data_out_d = {mem_q[idx], mem_q[idx1]};
      end
    end
  end

  // Storage array; cleared asynchronously so an interrupted store leaves nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (do_store) begin
      if (byte_enable) begin
        mem_q[idx] <= Data_in[7:0];
      end else begin
        mem_q[idx]  <= Data_in[15:8];
        mem_q[idx1] <= Data_in[7:0];
      end
    end
  end

  // Registered load result and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign Data_out = data_out_q;
  assign addr_err = addr_err_q;

  // Debug peek: a 9-bit peek address always fits when DEPTH covers it.
  if (DEPTH >= 512) begin : g_dbg_full
    always_comb begin
      dbg_data = mem_q[IDX_W'(dbg_addr)];
    end
  end else begin : g_dbg_guard
    localparam logic [9:0] DBG_LIM = DEPTH[9:0];
    always_comb begin
      dbg_data = '0;
      if ({1'b0, dbg_addr} < DBG_LIM)
        dbg_data = mem_q[dbg_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: a reference byte array predicts every
// access, the prediction is queued when stimulus is driven and compared after
// the sampling edge.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dm_enable = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] Data_in = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        byte_enable = 1'b0;
  logic [15:0] Data_out;
  logic        addr_err;
  logic [8:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(512), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .dm_enable(dm_enable), .address(address),
    .Data_in(Data_in), .MemWrite(MemWrite), .MemRead(MemRead),
    .byte_enable(byte_enable), .Data_out(Data_out), .addr_err(addr_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [512];
  logic [15:0] ref_out;
  logic        ref_err;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    ref_out = 16'h0000;
    ref_err = 1'b0;
  endtask

  // One clocked access: predict, queue, drive, then compare after the edge.
  task automatic acc(input string tag, input bit en, input bit wr, input bit rd,
                     input bit be, input logic [15:0] a, input logic [15:0] d);
    int   ai;
    bit   ok;
    exp_t e;
    ai = int'(a);
    ok = be ? (ai < 512) : (ai + 1 < 512);
    if (en && (wr || rd)) begin
      ref_err = !ok;
      if (wr) begin
        if (ok) begin
          if (be) ref_mem[ai] = d[7:0];
          else begin
            ref_mem[ai]     = d[15:8];
            ref_mem[ai + 1] = d[7:0];
          end
        end
      end else if (!ok) ref_out = 16'h0000;
      else if (be)      ref_out = {8'h00, ref_mem[ai]};
      else              ref_out = {ref_mem[ai], ref_mem[ai + 1]};
    end
    e.tag  = tag;
    e.data = ref_out;
    e.err  = ref_err;
    sb.push_back(e);
    dm_enable   = en;
    MemWrite    = wr;
    MemRead     = rd;
    byte_enable = be;
    address     = a;
    Data_in     = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".data"}, Data_out, e.data);
    chk({e.tag, ".err"}, {15'b0, addr_err}, {15'b0, e.err});
    dm_enable = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [8:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {8'h00, dbg_data}, {8'h00, exp});
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst.data", Data_out, 16'h0000);
    chk("rst.err", {15'b0, addr_err}, 16'h0000);
    peek("rst.peek", 9'h010, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // T1
    acc("t1_ld", 1, 0, 1, 0, 16'h0010, 16'h0000);
    chk("t1_const", Data_out, 16'h0000);

    // T2
    acc("t2_st", 1, 1, 0, 0, 16'h0010, 16'hABCD);
    acc("t2_ld", 1, 0, 1, 0, 16'h0010, 16'h0000);
    chk("t2_const", Data_out, 16'hABCD);
    peek("t2_pk10", 9'h010, 8'hAB);
    peek("t2_pk11", 9'h011, 8'hCD);

    // T3: upper byte of store data must be ignored
    acc("t3_st", 1, 1, 0, 1, 16'h0020, 16'h99EF);
    acc("t3_ld", 1, 0, 1, 1, 16'h0020, 16'h0000);
    chk("t3_const", Data_out, 16'h00EF);
    acc("t3_ld11", 1, 0, 1, 1, 16'h0011, 16'h0000);
    chk("t3_const11", Data_out, 16'h00CD);
    peek("t3_pk21", 9'h021, 8'h00);

    // T4 and range boundaries
    acc("t4_st1ff", 1, 1, 0, 0, 16'h01FF, 16'h1234);
    chk("t4_err", {15'b0, addr_err}, 16'h0001);
    peek("t4_pk1ff", 9'h1FF, 8'h00);
    acc("t4_ld200", 1, 0, 1, 0, 16'h0200, 16'h0000);
    chk("t4_const200", Data_out, 16'h0000);
    acc("t4_ld10", 1, 0, 1, 0, 16'h0010, 16'h0000);
    chk("t4_errclr", {15'b0, addr_err}, 16'h0000);
    acc("b_st1fe", 1, 1, 0, 0, 16'h01FE, 16'hBEEF);
    acc("b_ld1fe", 1, 0, 1, 0, 16'h01FE, 16'h0000);
    chk("b_const1fe", Data_out, 16'hBEEF);
    acc("b_ldb1ff", 1, 0, 1, 1, 16'h01FF, 16'h0000);
    acc("b_ldb200", 1, 0, 1, 1, 16'h0200, 16'h0000);
    acc("b_idle", 1, 0, 0, 0, 16'h0010, 16'h0000);
    chk("b_errhold", {15'b0, addr_err}, 16'h0001);
    acc("b_ldhi", 1, 0, 1, 1, 16'h8010, 16'h0000);
    acc("b_sthi", 1, 1, 0, 1, 16'h8010, 16'h0077);
    peek("b_pkhi", 9'h010, 8'hAB);

    // T5
    acc("t5_ld", 1, 0, 1, 0, 16'h0010, 16'h0000);
    acc("t5_dis_st", 0, 1, 0, 0, 16'h0010, 16'h5555);
    peek("t5_pk10", 9'h010, 8'hAB);
    chk("t5_hold", Data_out, 16'hABCD);
    acc("t5_dis_ld", 0, 0, 1, 0, 16'h0300, 16'h0000);
    acc("t5_both", 1, 1, 1, 0, 16'h0030, 16'h1357);
    chk("t5_bothhold", Data_out, 16'hABCD);
    peek("t5_pk30", 9'h030, 8'h13);
    peek("t5_pk31", 9'h031, 8'h57);
    acc("t5_ld30", 1, 0, 1, 0, 16'h0030, 16'h0000);

    // Mixed traffic around the top of memory
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(32'h1F0, 32'h204));
      if (i % 4 == 3) a = 16'($urandom_range(0, 15));
      acc($sformatf("rnd%0d", i), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), a, 16'($urandom));
    end

    // T6: asynchronous reset between edges
    acc("t6_st", 1, 1, 0, 0, 16'h0010, 16'hABCD);
    acc("t6_ld", 1, 0, 1, 0, 16'h0010, 16'h0000);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async.data", Data_out, 16'h0000);
    chk("t6_async.err", {15'b0, addr_err}, 16'h0000);
    peek("t6_pk10", 9'h010, 8'h00);
    #6;
    rst_n = 1'b1;
    // Store interrupted by reset before its edge must leave no trace
    dm_enable = 1'b1; MemWrite = 1'b1; byte_enable = 1'b0;
    address = 16'h0010; Data_in = 16'h4242;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    dm_enable = 1'b0; MemWrite = 1'b0;
    #3;
    rst_n = 1'b1;
    peek("t6_abort", 9'h010, 8'h00);
    acc("t6_ld_after", 1, 0, 1, 0, 16'h0010, 16'h0000);
    chk("t6_const", Data_out, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
